// File: rtl/keypad_scan_fifo.sv
// Keypad matrix scanner: synchronises and debounces active-low row returns, encodes
// each accepted press as row*COLS+col, and queues codes in a FIFO with sticky overflow.
module keypad_scan_fifo #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int REPEAT_CYCLES   = 0,
    parameter int FIFO_DEPTH      = 4,
    localparam int CODE_W         = $clog2(ROWS*COLS),
    localparam int CNT_W          = $clog2(FIFO_DEPTH+1)
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic [ROWS-1:0]   RowIn,
    output logic [COLS-1:0]   ColOut,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic [CNT_W-1:0]  key_count,
    output logic              overflow,
    input  logic              ovf_clr
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = $clog2(COLS);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = $clog2(DEBOUNCE_CYCLES+1);
    localparam int PW = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES+1) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [COLS-1:0] COL_ONE = {{(COLS-1){1'b0}}, 1'b1};

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    logic [ROWS-1:0]   sync1_r, rs_r;
    logic [1:0]        state_r, state_nxt_s;
    logic [CW-1:0]     col_r, col_nxt_s, col_inc_s;
    logic [COLS-1:0]   col_out_r;
    logic [RW-1:0]     row_r, row_nxt_s, low_row_s;
    logic [DW-1:0]     dwell_r, dwell_nxt_s;
    logic [BW-1:0]     cnt_r, cnt_nxt_s, cnt_inc_s;
    logic [PW-1:0]     rep_r, rep_nxt_s, rep_inc_s;
    logic              push_s, any_low_s, row_bit_s;
    logic [CODE_W-1:0] code_s;

    logic [CODE_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              overflow_r, full_s, pop_s, wr_s, ovf_set_s;

    // Two-flop synchroniser on the raw rows, idle value all ones
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            sync1_r <= {ROWS{1'b1}};
            rs_r    <= {ROWS{1'b1}};
        end else begin
            sync1_r <= RowIn;
            rs_r    <= sync1_r;
        end
    end

    // Lowest-index low row wins when several rows return in one column
    always_comb begin
        low_row_s = {RW{1'b0}};
        for (int i = ROWS-1; i >= 0; i--) begin
            low_row_s = rs_r[i] ? low_row_s : RW'(i);
        end
    end

    assign any_low_s = ~&rs_r;
    assign row_bit_s = rs_r[row_r];
    assign col_inc_s = (col_r == CW'(COLS-1)) ? {CW{1'b0}} : col_r + CW'(1);
    assign cnt_inc_s = cnt_r + BW'(1);
    assign rep_inc_s = rep_r + PW'(1);
    assign code_s    = CODE_W'(32'(row_r) * COLS + 32'(col_r));

    // Scan / debounce / hold / release next-state logic
    always_comb begin
        state_nxt_s = state_r;
        col_nxt_s   = col_r;
        row_nxt_s   = row_r;
        dwell_nxt_s = dwell_r;
        cnt_nxt_s   = cnt_r;
        rep_nxt_s   = rep_r;
        push_s      = 1'b0;
        case (state_r)
            ST_SCAN: begin
                if (dwell_r == DW'(SCAN_DIV-1)) begin
                    dwell_nxt_s = {DW{1'b0}};
                    if (any_low_s) begin
                        row_nxt_s   = low_row_s;
                        cnt_nxt_s   = {BW{1'b0}};
                        state_nxt_s = ST_DEBOUNCE;
                    end else begin
                        col_nxt_s = col_inc_s;
                    end
                end else begin
                    dwell_nxt_s = dwell_r + DW'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (!row_bit_s) begin
                    if (cnt_inc_s == BW'(DEBOUNCE_CYCLES)) begin
                        push_s      = 1'b1;
                        rep_nxt_s   = {PW{1'b0}};
                        state_nxt_s = ST_HELD;
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end else begin
                    dwell_nxt_s = {DW{1'b0}};
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_HELD: begin
                if (row_bit_s) begin
                    cnt_nxt_s   = {BW{1'b0}};
                    state_nxt_s = ST_RELEASE;
                end else if (REPEAT_CYCLES > 0) begin
                    if (rep_inc_s == PW'(REPEAT_CYCLES)) begin
                        push_s    = 1'b1;
                        rep_nxt_s = {PW{1'b0}};
                    end else begin
                        rep_nxt_s = rep_inc_s;
                    end
                end else begin
                    rep_nxt_s = {PW{1'b0}};
                end
            end
            ST_RELEASE: begin
                if (row_bit_s) begin
                    if (cnt_inc_s == BW'(DEBOUNCE_CYCLES)) begin
                        col_nxt_s   = col_inc_s;
                        dwell_nxt_s = {DW{1'b0}};
                        state_nxt_s = ST_SCAN;
                    end else begin
                        cnt_nxt_s = cnt_inc_s;
                    end
                end else begin
                    // Bounce back to held: repeat timing restarts, no new push
                    rep_nxt_s   = {PW{1'b0}};
                    state_nxt_s = ST_HELD;
                end
            end
            default: begin
                dwell_nxt_s = {DW{1'b0}};
                state_nxt_s = ST_SCAN;
            end
        endcase
    end

    // Scan FSM registers, with the one-cold column drive kept registered
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_r   <= ST_SCAN;
            col_r     <= {CW{1'b0}};
            col_out_r <= ~COL_ONE;
            row_r     <= {RW{1'b0}};
            dwell_r   <= {DW{1'b0}};
            cnt_r     <= {BW{1'b0}};
            rep_r     <= {PW{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            col_r     <= col_nxt_s;
            col_out_r <= ~(COL_ONE << col_nxt_s);
            row_r     <= row_nxt_s;
            dwell_r   <= dwell_nxt_s;
            cnt_r     <= cnt_nxt_s;
            rep_r     <= rep_nxt_s;
        end
    end

    assign full_s    = (count_r == CNT_W'(FIFO_DEPTH));
    assign pop_s     = (count_r != {CNT_W{1'b0}}) && key_ready;
    assign wr_s      = push_s && (!full_s || pop_s);
    assign ovf_set_s = push_s && full_s && !pop_s;

    // Key storage; stale entries are harmless because the head is masked when empty
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= code_s;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers, occupancy and sticky overflow (set beats clear)
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            if (wr_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            else      wr_ptr_r <= wr_ptr_r;
            if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
            else       rd_ptr_r <= rd_ptr_r;
            case ({wr_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            if (ovf_set_s)    overflow_r <= 1'b1;
            else if (ovf_clr) overflow_r <= 1'b0;
            else              overflow_r <= overflow_r;
        end
    end

    assign ColOut    = col_out_r;
    assign key_valid = (count_r != {CNT_W{1'b0}});
    assign key_code  = key_valid ? mem_r[rd_ptr_r] : {CODE_W{1'b0}};
    assign key_count = count_r;
    assign overflow  = overflow_r;
endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo: a 4x4 switch-matrix model drives RowIn from ColOut.
module tb_keypad_scan_fifo;
    logic        clk = 1'b0;
    logic        nRST;
    logic [3:0]  RowIn;
    logic [3:0]  ColOut;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic [2:0]  key_count;
    logic        overflow;
    logic        ovf_clr;
    logic [15:0] keys;
    int          checks   = 0;
    int          failures = 0;

    keypad_scan_fifo #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_CYCLES(8),
        .REPEAT_CYCLES(20), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .nRST(nRST), .RowIn(RowIn), .ColOut(ColOut),
        .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
        .key_count(key_count), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Pressed switch shorts its row to the column currently driven low
    always_comb begin
        RowIn = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !ColOut[c]) RowIn[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] colpat(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << c);
    endfunction

    // Press a key just before its column comes round; returns right after edge E
    // where the column is first driven, so the push lands on edge E+12.
    task automatic arm_key(input int code);
        int c, p, n;
        c = code % 4;
        p = (c + 3) % 4;
        n = 0;
        while (ColOut !== colpat(p) && n < 200) begin tick(1); n++; end
        chk("arm_prev_col", ColOut, colpat(p));
        keys[code] = 1'b1;
        n = 0;
        while (ColOut !== colpat(c) && n < 200) begin tick(1); n++; end
        chk("arm_key_col", ColOut, colpat(c));
    endtask

    task automatic press_key(input int code, input bit pop_at_push);
        arm_key(code);
        tick(11);
        if (pop_at_push) key_ready = 1'b1;
        tick(1);
        key_ready  = 1'b0;
        keys[code] = 1'b0;
    endtask

    task automatic drain(input logic [3:0] code);
        chk("drain_valid", key_valid, 1'b1);
        chk("drain_code", key_code, code);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
    endtask

    initial begin
        int n;
        nRST = 1'b0; key_ready = 1'b0; ovf_clr = 1'b0;
        keys = 16'h0040;   // key 6 (row1,col2) held from the start
        #23;
        @(negedge clk) nRST = 1'b1;

        // Reset values and column dwell timing
        tick(3);
        chk("rst_colout", ColOut, 4'b1110);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_code", key_code, 4'd0);
        chk("rst_count", key_count, 3'd0);
        chk("rst_ovf", overflow, 1'b0);
        tick(1);
        chk("dwell_col1", ColOut, 4'b1101);

        // Single press: column 2 first driven at edge 8, push at edge 20
        tick(15);
        chk("single_frozen_col", ColOut, 4'b1011);
        chk("single_not_yet", key_valid, 1'b0);
        tick(1);
        chk("single_valid", key_valid, 1'b1);
        chk("single_code", key_code, 4'd6);
        chk("single_count", key_count, 3'd1);
        keys[6] = 1'b0;
        tick(5);
        chk("single_stall_code", key_code, 4'd6);
        chk("single_stall_count", key_count, 3'd1);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
        chk("single_pop_valid", key_valid, 1'b0);
        chk("single_pop_count", key_count, 3'd0);
        chk("single_pop_code", key_code, 4'd0);

        // Bounce rejection on key 3, then a stable press
        n = 0;
        while (ColOut !== 4'b1011 && n < 200) begin tick(1); n++; end
        chk("bounce_start_col", ColOut, 4'b1011);
        repeat (8) begin
            keys[3] = 1'b1; tick(5);
            keys[3] = 1'b0; tick(1);
        end
        chk("bounce_no_push", key_count, 3'd0);
        keys[3] = 1'b1;
        n = 0;
        while (key_valid !== 1'b1 && n < 200) begin tick(1); n++; end
        keys[3] = 1'b0;
        chk("bounce_accept_valid", key_valid, 1'b1);
        chk("bounce_accept_count", key_count, 3'd1);
        drain(4'd3);

        // "3 + 4 =" with consumer stalled
        press_key(2, 1'b0);
        press_key(3, 1'b0);
        press_key(4, 1'b0);
        press_key(12, 1'b0);
        chk("seq_count", key_count, 3'd4);
        drain(4'd2); drain(4'd3); drain(4'd4); drain(4'd12);
        chk("seq_empty", key_count, 3'd0);

        // Overflow: fifth press dropped, then clear
        press_key(0, 1'b0);
        press_key(1, 1'b0);
        press_key(2, 1'b0);
        press_key(3, 1'b0);
        chk("ovf_full_count", key_count, 3'd4);
        arm_key(5);
        tick(11);
        chk("ovf_before", overflow, 1'b0);
        tick(1);
        keys[5] = 1'b0;
        chk("ovf_set", overflow, 1'b1);
        chk("ovf_count", key_count, 3'd4);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("ovf_cleared", overflow, 1'b0);
        // Push while full with a same-cycle pop: both succeed
        press_key(6, 1'b1);
        chk("full_pp_count", key_count, 3'd4);
        chk("full_pp_ovf", overflow, 1'b0);
        drain(4'd1); drain(4'd2); drain(4'd3); drain(4'd6);
        chk("ovf_empty", key_valid, 1'b0);

        // Hold-to-repeat on key 5: pushes at E+12, +20, +40, +60
        arm_key(5);
        tick(11);
        chk("rep_pre_accept", key_count, 3'd0);
        tick(1);
        chk("rep_accept", key_count, 3'd1);
        tick(19);
        chk("rep_before_first", key_count, 3'd1);
        tick(1);
        chk("rep_first", key_count, 3'd2);
        tick(50);
        chk("rep_at_70", key_count, 3'd4);
        keys[5] = 1'b0;
        tick(30);
        chk("rep_after_release", key_count, 3'd4);
        drain(4'd5); drain(4'd5); drain(4'd5); drain(4'd5);

        // Reset while held with two entries queued
        press_key(1, 1'b0);
        arm_key(6);
        tick(12);
        chk("rst_hold_count", key_count, 3'd2);
        nRST = 1'b0;
        #1;
        chk("rst_mid_colout", ColOut, 4'b1110);
        chk("rst_mid_count", key_count, 3'd0);
        chk("rst_mid_valid", key_valid, 1'b0);
        chk("rst_mid_code", key_code, 4'd0);
        keys[6] = 1'b0;
        @(negedge clk) nRST = 1'b1;
        tick(3);
        chk("rst_resume_col0", ColOut, 4'b1110);
        tick(1);
        chk("rst_resume_col1", ColOut, 4'b1101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
